// File: rtl/conv_mem_host_if.sv
// conv_mem_host_if: CONV-side handshake, image fetch and layer-memory bus
interface conv_mem_host_if;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    modport master (input ready, idata, cdata_rd,
                    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel);
    modport slave  (output ready, idata, cdata_rd,
                    input busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel);
endinterface

// File: rtl/conv_mem_host.sv
// conv_mem_host: image ROM, layer-0/1 memories and start/done sequencing for a CONV engine
module conv_mem_host #(
    parameter int IMG_WORDS   = 4096,
    parameter int L0_WORDS    = 4096,
    parameter int L1_WORDS    = 1024,
    parameter int REQ_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    conv_mem_host_if.slave bus,
    input  logic        ld_en,
    input  logic [19:0] ld_data,
    input  logic        start,
    input  logic        rb_en,
    input  logic        rb_sel,
    input  logic [11:0] rb_addr,
    output logic [19:0] rb_data,
    output logic        done,
    output logic [3:0]  err
);
    localparam int IPW = $clog2(IMG_WORDS);
    localparam int L0A = $clog2(L0_WORDS);
    localparam int L1A = $clog2(L1_WORDS);
    localparam int L0C = $clog2(L0_WORDS + 1);
    localparam int L1C = $clog2(L1_WORDS + 1);
    localparam int TW  = $clog2(REQ_TIMEOUT);
    localparam logic [11:0] L1_LIM = 12'(L1_WORDS);
    typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [19:0] img [IMG_WORDS];
    logic [19:0] l0 [L0_WORDS];
    logic [19:0] l1 [L1_WORDS];
    logic [IPW-1:0] ld_ptr;
    logic [L0C-1:0] l0_cnt;
    logic [L1C-1:0] l1_cnt;
    logic [TW-1:0]  tcnt;
    logic idle, run, go, sel_l0, sel_l1, l1_wr_ok, l1_rd_ok, l0_we, l1_we, tmo;
    logic [3:0] err_set;
    always_comb begin
        idle     = state == IDLE;
        run      = state == RUN;
        go       = idle & start;
        sel_l0   = bus.csel == 3'b001;
        sel_l1   = bus.csel == 3'b011;
        l1_wr_ok = bus.caddr_wr < L1_LIM;
        l1_rd_ok = bus.caddr_rd < L1_LIM;
        l0_we    = run & bus.cwr & sel_l0;
        l1_we    = run & bus.cwr & sel_l1 & l1_wr_ok;
        tmo      = (state == REQ) & !bus.busy & (tcnt == TW'(REQ_TIMEOUT - 1));
        // {timeout, l1_range, bad_csel, wr_outside_run}
        err_set  = {tmo, bus.cwr & sel_l1 & !l1_wr_ok, (bus.cwr | bus.crd) & !sel_l0 & !sel_l1, bus.cwr & !run};
        state_nx = idle ? (start ? REQ : IDLE) :
                   state == REQ ? (bus.busy ? RUN : (tmo ? IDLE : REQ)) :
                   run ? (bus.busy ? RUN : DONE) : IDLE;
        bus.idata    = img[bus.iaddr[IPW-1:0]];
        bus.cdata_rd = !bus.crd ? '0 :
                       sel_l0 ? l0[bus.caddr_rd[L0A-1:0]] :
                       (sel_l1 && l1_rd_ok) ? l1[bus.caddr_rd[L1A-1:0]] : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bus.ready <= 1'b0;
            done      <= 1'b0;
            rb_data   <= '0;
            err       <= '0;
            ld_ptr    <= '0;
            l0_cnt    <= '0;
            l1_cnt    <= '0;
            tcnt      <= '0;
        end else begin
            state     <= state_nx;
            bus.ready <= state_nx == REQ;
            done      <= state_nx == DONE;
            err       <= (go ? 4'b0 : err) | err_set;
            tcnt      <= (state == REQ) ? tcnt + 1'b1 : '0;
            ld_ptr    <= go ? '0 : ld_ptr + IPW'(idle & ld_en);
            l0_cnt    <= go ? '0 : l0_cnt + L0C'(l0_we);
            l1_cnt    <= go ? '0 : l1_cnt + L1C'(l1_we);
            if (idle & rb_en)
                rb_data <= rb_sel ? ((rb_addr < L1_LIM) ? l1[rb_addr[L1A-1:0]] : '0) : l0[rb_addr[L0A-1:0]];
        end
    end
    // Memories are deliberately left out of reset so results survive an aborted run.
    always_ff @(posedge clk) begin
        if (idle & ld_en) img[ld_ptr] <= ld_data;
        if (l0_we) l0[bus.caddr_wr[L0A-1:0]] <= bus.cdata_wr;
        if (l1_we) l1[bus.caddr_wr[L1A-1:0]] <= bus.cdata_wr;
    end
endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: directed self-checking bench for conv_mem_host
module tb_conv_mem_host;
    logic clk = 0, reset = 0, ld_en = 0, start = 0, rb_en = 0, rb_sel = 0;
    logic [19:0] ld_data = '0;
    logic [11:0] rb_addr = '0;
    logic [19:0] rb_data;
    logic done;
    logic [3:0] err;
    int checks = 0, errors = 0, done_cnt = 0;

    conv_mem_host_if bus();

    conv_mem_host dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ld_en(ld_en), .ld_data(ld_data), .start(start),
        .rb_en(rb_en), .rb_sel(rb_sel), .rb_addr(rb_addr),
        .rb_data(rb_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [19:0] obs, logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bus.busy = 0; bus.iaddr = '0; bus.cwr = 0; bus.caddr_wr = '0; bus.cdata_wr = '0;
        bus.crd = 0; bus.caddr_rd = '0; bus.csel = 3'b001;
        step(2);
        chk("rst_ready", 20'(bus.ready), 20'h0);
        chk("rst_done", 20'(done), 20'h0);
        chk("rst_err", 20'(err), 20'h0);
        chk("rst_rb", rb_data, 20'h0);
        reset = 1;
        step();
        ld_en = 1;
        for (int i = 0; i < 4096; i++) begin
            ld_data = 20'(i);
            step();
        end
        ld_en = 0;
        bus.iaddr = 12'd4095; #1;
        chk("idata_4095", bus.idata, 20'h00fff);
        bus.cwr = 1; bus.caddr_wr = 12'd10; bus.cdata_wr = 20'h12345;
        step();
        bus.cwr = 0;
        chk("err_wr_idle", 20'(err), 20'h1);

        start = 1; step(); start = 0;
        chk("req_ready_c1", 20'(bus.ready), 20'h1);
        chk("start_clr_err", 20'(err), 20'h0);
        step();
        chk("req_ready_c2", 20'(bus.ready), 20'h1);
        bus.busy = 1; step();
        chk("run_ready", 20'(bus.ready), 20'h0);
        bus.iaddr = 12'd65; #1;
        chk("idata_65", bus.idata, 20'h00041);

        bus.cwr = 1; bus.csel = 3'b001;
        for (int a = 0; a < 4096; a++) begin
            bus.caddr_wr = 12'(a);
            bus.cdata_wr = (a == 10) ? 20'h01310 : 20'h30000 + 20'(a);
            step();
        end
        bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'd10; #1;
        chk("crd_l0_10", bus.cdata_rd, 20'h01310);
        bus.crd = 0; bus.cwr = 1; bus.csel = 3'b011;
        for (int a = 0; a < 1024; a++) begin
            bus.caddr_wr = 12'(a);
            bus.cdata_wr = 20'h80000 + 20'(a);
            step();
        end
        bus.caddr_wr = 12'd1024; bus.cdata_wr = 20'hdead0;
        step();
        chk("err_l1_range", 20'(err), 20'h4);
        bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'd5; #1;
        chk("crd_l1_5", bus.cdata_rd, 20'h80005);
        bus.csel = 3'b010; #1;
        chk("crd_bad_csel", bus.cdata_rd, 20'h0);
        bus.cwr = 1; step();
        chk("err_bad_csel", 20'(err), 20'h6);
        bus.cwr = 0; bus.crd = 0; bus.csel = 3'b001;
        chk("l0_cnt", 20'(dut.l0_cnt), 20'd4096);
        chk("l1_cnt", 20'(dut.l1_cnt), 20'd1024);
        bus.busy = 0; step();
        chk("done_pulse", 20'(done), 20'h1);
        step();
        chk("done_low", 20'(done), 20'h0);
        chk("done_once", 20'(done_cnt), 20'd1);

        rb_en = 1; rb_sel = 0; rb_addr = 12'd10; step();
        chk("rb_l0_10", rb_data, 20'h01310);
        rb_addr = 12'd1023; step();
        chk("rb_l0_1023", rb_data, 20'h303ff);
        rb_sel = 1; rb_addr = 12'd5; step();
        chk("rb_l1_5", rb_data, 20'h80005);
        rb_addr = 12'd1024; step();
        chk("rb_l1_1024", rb_data, 20'h0);
        rb_addr = 12'd1023; step();
        chk("rb_l1_1023", rb_data, 20'h803ff);
        rb_en = 0;
        chk("err_sticky", 20'(err), 20'h6);

        start = 1; step(); start = 0;
        chk("tmo_ready", 20'(bus.ready), 20'h1);
        chk("tmo_err_clr", 20'(err), 20'h0);
        step(15);
        chk("tmo_ready_15", 20'(bus.ready), 20'h1);
        step();
        chk("tmo_ready_16", 20'(bus.ready), 20'h0);
        chk("tmo_err", 20'(err), 20'h8);
        chk("tmo_no_done", 20'(done_cnt), 20'd1);

        rb_en = 1; rb_sel = 0; rb_addr = 12'd20; step(); rb_en = 0;
        chk("rb_l0_20", rb_data, 20'h30014);
        start = 1; step(); start = 0;
        bus.busy = 1; step();
        rb_en = 1; rb_addr = 12'd10; step(); rb_en = 0;
        chk("rb_hold_run", rb_data, 20'h30014);
        bus.cwr = 1; bus.caddr_wr = 12'd20; bus.cdata_wr = 20'hbeef0;
        bus.crd = 1; bus.caddr_rd = 12'd20; #1;
        chk("raw_old", bus.cdata_rd, 20'h30014);
        step();
        bus.cwr = 0; #1;
        chk("raw_new", bus.cdata_rd, 20'hbeef0);
        bus.crd = 0;
        #2 reset = 0; #1;
        chk("async_rb", rb_data, 20'h0);
        chk("async_ready", 20'(bus.ready), 20'h0);
        step(2);
        reset = 1; bus.busy = 0;
        step();
        chk("rst_no_done", 20'(done_cnt), 20'd1);
        chk("rst_err_clr", 20'(err), 20'h0);
        rb_en = 1; rb_sel = 0; rb_addr = 12'd10; step();
        chk("rb_after_rst_10", rb_data, 20'h01310);
        rb_addr = 12'd20; step();
        chk("rb_after_rst_20", rb_data, 20'hbeef0);
        rb_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_mem_host.md
CONV_MEM_HOST -- requirements
Module: conv_mem_host

Interface
REQ-001 SHALL have parameter IMG_WORDS, default 4096, image ROM depth (64x64 pixels, row-major, addr = y*64+x).
REQ-002 SHALL have parameter L0_WORDS, default 4096, layer-0 memory depth (conv+ReLU output).
REQ-003 SHALL have parameter L1_WORDS, default 1024, layer-1 memory depth (2x2 max-pool output).
REQ-004 SHALL have parameter REQ_TIMEOUT, default 16, cycles allowed for CONV to raise busy after ready.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 ready  out  1  start request to CONV.
REQ-008 busy  in  1  CONV processing flag.
REQ-009 iaddr  in  12  image read address from CONV.
REQ-010 idata  out  20  image data for iaddr.
REQ-011 cwr  in  1  layer-memory write strobe.
REQ-012 caddr_wr  in  12  write address.
REQ-013 cdata_wr  in  20  write data.
REQ-014 crd  in  1  layer-memory read strobe.
REQ-015 caddr_rd  in  12  read address.
REQ-016 cdata_rd  out  20  read data for caddr_rd.
REQ-017 csel  in  3  bank select: 001 = L0, 011 = L1, others illegal.
REQ-018 ld_en  in  1  host image-load strobe.
REQ-019 ld_data  in  20  host image word (auto-incrementing address).
REQ-020 start  in  1  host start pulse.
REQ-021 rb_en, rb_sel, rb_addr  in  1/1/12  host readback strobe, bank (0=L0, 1=L1), address.
REQ-022 rb_data  out  20  registered readback data.
REQ-023 done  out  1  one-cycle completion pulse.
REQ-024 err  out  4  sticky error flags {timeout, l1_range, bad_csel, wr_outside_run}.

Function
REQ-025 FSM states IDLE, REQ, RUN, DONE; image load and readback only accepted in IDLE.
REQ-026 IDLE: ld_en=1 writes ld_data to image[ld_ptr], ld_ptr increments, wraps 4095->0; start=1 clears ld_ptr and L0/L1 write counters, moves to REQ.
REQ-027 REQ: ready=1 registered; first cycle busy=1 -> RUN, ready=0 next cycle; REQ_TIMEOUT cycles without busy -> set err[3], ready=0, IDLE.
REQ-028 RUN: on first cycle busy=0 -> DONE; DONE asserts done=1 one cycle, then IDLE.
REQ-029 idata SHALL be combinational image[iaddr], valid same cycle CONV drives iaddr so CONV samples it at the next edge.
REQ-030 cdata_rd SHALL be combinational read of bank chosen by csel at caddr_rd when crd=1; 0 when crd=0 or csel illegal.
REQ-031 Write at rising edge when cwr=1: csel=001 -> L0[caddr_wr]; csel=011 and caddr_wr<1024 -> L1[caddr_wr]; increment matching write counter.
REQ-032 cwr=1 with csel=011 and caddr_wr>=1024 SHALL discard write, set err[2].
REQ-033 cwr=1 or crd=1 with illegal csel SHALL discard access, set err[1].
REQ-034 cwr=1 outside RUN SHALL discard write, set err[0].
REQ-035 Same-address write and read in one cycle SHALL return old data on cdata_rd (write lands at edge).
REQ-036 rb_en=1 in IDLE: rb_data = selected bank word at rb_addr one cycle later; rb_addr>=1024 with rb_sel=1 returns 0; rb_en outside IDLE ignored, rb_data holds.
REQ-037 start outside IDLE SHALL be ignored; ld_en outside IDLE SHALL be ignored.
REQ-038 err SHALL be sticky until reset or next accepted start.

Reset
REQ-039 reset=0 SHALL immediately force state=IDLE, ready=0, done=0, rb_data=0, err=0, ld_ptr=0, counters=0; memory contents not cleared.
REQ-040 reset asserted mid-RUN SHALL abandon run with no done pulse; first cycle after release is IDLE.

Verification
REQ-041 Load 4096 words image[i]=i, start -> ready=1 next cycle; busy=1 at cycle 3 -> ready=0, RUN.
REQ-042 In RUN, iaddr=65 -> idata=20'h00041 same cycle; cwr=1, csel=001, caddr_wr=10, cdata_wr=20'h01310 -> L0 readback addr 10 returns 20'h01310.
REQ-043 cwr=1, csel=011, caddr_wr=1024 -> write dropped, err=4'b0100; csel=010 -> err[1] also set.
REQ-044 start with busy held 0 for 16 cycles -> ready drops, err[3]=1, IDLE, no done.
REQ-045 busy falls after full run -> done=1 exactly one cycle; L1 count=1024, L0 count=4096.
REQ-046 reset=0 during RUN -> ready=0, done never pulses, rb of L0 addr 10 still 20'h01310.
